vga_scanout: RTL and testbench

Display scan-out stage on the `gpu_clk` domain, directly downstream of the CPU's VRAM read port. It generates 640x480@60 VGA timing and drives `gpu_address` into the processor's video memory. It consumes the returned 8-bit `vram_out` sample and drives aligned grey-scale RGB plus sync to the DAC/pins. Image pixels are shown inside a configurable window; everything outside the window is black.

---
 rtl/vga_scanout_if.sv | 22 ++
 rtl/vga_scanout.sv | 136 +++++++++++++
 tb/tb_vga_scanout.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scanout_if.sv
// VRAM read port plus video pins of the scan-out stage.
interface vga_scanout_if;
    logic [31:0] gpu_address;
    logic [7:0]  vram_in;
    logic        hsync;
    logic        vsync;
    logic        blank_n;
    logic        frame_start;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;

    modport master (
        output gpu_address, hsync, vsync, blank_n, frame_start, r, g, b,
        input  vram_in
    );

    modport slave (
        input  gpu_address, hsync, vsync, blank_n, frame_start, r, g, b,
        output vram_in
    );
endinterface

// File: rtl/vga_scanout.sv
// VGA scan-out: raster counters, windowed VRAM addressing and a 3-cycle aligned output pipe.
// Define VGA_SCANOUT_PIXEL_DOUBLE_EN to show each image pixel as a 2x2 screen block.
module vga_scanout #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned IMG_W     = 240,
    parameter int unsigned IMG_H     = 240,
    parameter int unsigned X0        = 0,
    parameter int unsigned Y0        = 0,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic          gpu_clk,
    input  logic          rst,
    input  logic          display_en,
    vga_scanout_if.master bus
);

`ifdef VGA_SCANOUT_PIXEL_DOUBLE_EN
    localparam int unsigned SHIFT = 1;
`else
    localparam int unsigned SHIFT = 0;
`endif

    localparam int unsigned WIN_W    = IMG_W << SHIFT;
    localparam int unsigned WIN_H    = IMG_H << SHIFT;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank_n;
        logic in_win;
        logic frame_start;
    } pipe_t;

    localparam pipe_t PIPE_IDLE = '{
        hsync: 1'b1, vsync: 1'b1, blank_n: 1'b0, in_win: 1'b0, frame_start: 1'b0
    };

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [31:0]   h32, v32, dx, dy, xi, yi;
    logic          active, in_win;
    logic [31:0]   addr_q, addr_d;
    pipe_t         s1_q, s1_d, s2_q;
    logic          hsync_q, vsync_q, blank_q, fs_q;
    logic [7:0]    pix_q, pix_d;

    assign h32 = 32'(h_cnt_q);
    assign v32 = 32'(v_cnt_q);

    always_comb begin
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h32 == H_TOTAL - 1) begin
            h_cnt_d = '0;
            v_cnt_d = (v32 == V_TOTAL - 1) ? '0 : v_cnt_q + VW'(1);
        end
    end

    // Offsets left of / above the origin wrap to huge values, so one unsigned compare per
    // axis covers both window bounds.
    assign dx     = h32 - X0;
    assign dy     = v32 - Y0;
    assign xi     = dx >> SHIFT;
    assign yi     = dy >> SHIFT;
    assign active = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
    assign in_win = active && (dx < WIN_W) && (dy < WIN_H);

    always_comb begin
        addr_d         = in_win ? (BASE_ADDR + yi * IMG_W + xi) : BASE_ADDR;
        s1_d           = PIPE_IDLE;
        s1_d.hsync     = !((h32 >= HS_START) && (h32 < HS_END));
        s1_d.vsync     = !((v32 >= VS_START) && (v32 < VS_END));
        s1_d.blank_n   = active;
        s1_d.in_win    = in_win;
        s1_d.frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // vram_in belongs to the pixel now in stage 2; display_en is taken at this same edge.
    always_comb begin
        pix_d = 8'h00;
        if (s2_q.blank_n && s2_q.in_win && display_en) begin
            pix_d = bus.vram_in;
        end
    end

    always_ff @(posedge gpu_clk or negedge rst) begin
        if (!rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            addr_q  <= BASE_ADDR;
            s1_q    <= PIPE_IDLE;
            s2_q    <= PIPE_IDLE;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
            pix_q   <= 8'h00;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            addr_q  <= addr_d;
            s1_q    <= s1_d;
            s2_q    <= s1_q;
            hsync_q <= s2_q.hsync;
            vsync_q <= s2_q.vsync;
            blank_q <= s2_q.blank_n;
            fs_q    <= s2_q.frame_start;
            pix_q   <= pix_d;
        end
    end

    assign bus.gpu_address = addr_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.blank_n     = blank_q;
    assign bus.frame_start = fs_q;
    assign bus.r           = pix_q;
    assign bus.g           = pix_q;
    assign bus.b           = pix_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunken raster: per-pixel scoreboard plus directed scenarios.
module tb_vga_scanout;

    localparam int H_ACTIVE = 40;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 6;
    localparam int H_BP     = 4;
    localparam int V_ACTIVE = 30;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int IMG_W    = 20;
    localparam int IMG_H    = 12;
    localparam int X0       = 4;
    localparam int Y0       = 2;
    localparam logic [31:0] BASE = 32'h10A5;
`ifdef VGA_SCANOUT_PIXEL_DOUBLE_EN
    localparam int S = 2;
    localparam int AX = 7, AY = 5;
    localparam int LAST_X = 39, AFTER_X = 40, BLACK_V = 26;
    localparam logic [31:0] LAST_ADDR = 32'h10B6;
    localparam logic AFTER_BL = 1'b0;
`else
    localparam int S = 1;
    localparam int AX = 5, AY = 3;
    localparam int LAST_X = 23, AFTER_X = 24, BLACK_V = 14;
    localparam logic [31:0] LAST_ADDR = 32'h10B8;
    localparam logic AFTER_BL = 1'b1;
`endif
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME   = H_TOTAL * V_TOTAL;
    localparam int WIN_W   = IMG_W * S;
    localparam int WIN_H   = IMG_H * S;
    localparam logic [27:0] RST_OUT = {4'b1100, 24'h0};

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        bl;
        logic        iw;
        logic        fs;
        logic [31:0] addr;
    } exp_t;

    logic gpu_clk = 1'b0;
    logic rst = 1'b0;
    logic display_en = 1'b1;
    int   checks = 0;
    int   failures = 0;

    vga_scanout_if bus ();

    vga_scanout #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .IMG_W(IMG_W), .IMG_H(IMG_H), .X0(X0), .Y0(Y0), .BASE_ADDR(BASE)
    ) dut (
        .gpu_clk(gpu_clk),
        .rst(rst),
        .display_en(display_en),
        .bus(bus)
    );

    always #5 gpu_clk = ~gpu_clk;

    // Synchronous RAM returning the low address byte one cycle later.
    always @(posedge gpu_clk) bus.vram_in <= bus.gpu_address[7:0];

    wire [27:0] outv = {bus.hsync, bus.vsync, bus.blank_n, bus.frame_start, bus.r, bus.g, bus.b};

    function automatic exp_t make_exp(input int h, input int v);
        exp_t e;
        e.hs   = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
        e.vs   = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
        e.bl   = (h < H_ACTIVE) && (v < V_ACTIVE);
        e.iw   = e.bl && (h >= X0) && (h < X0 + WIN_W) && (v >= Y0) && (v < Y0 + WIN_H);
        e.fs   = (h == 0) && (v == 0);
        e.addr = e.iw ? BASE + 32'(((v - Y0) / S) * IMG_W + (h - X0) / S) : BASE;
        return e;
    endfunction

    // Reference raster: one expected record per evaluated pixel.
    exp_t q[$];
    int   mh, mv, last_h, last_v;
    logic de_s;

    always @(posedge gpu_clk or negedge rst) begin
        if (!rst) begin
            mh     <= 0;
            mv     <= 0;
            last_h <= 0;
            last_v <= 0;
            de_s   <= 1'b1;
            q.delete();
        end else begin
            q.push_back(make_exp(mh, mv));
            last_h <= mh;
            last_v <= mv;
            de_s   <= display_en;
            if (mh == H_TOTAL - 1) begin
                mh <= 0;
                mv <= (mv == V_TOTAL - 1) ? 0 : mv + 1;
            end else begin
                mh <= mh + 1;
            end
        end
    end

    // Scoreboard: address of the newest pixel, outputs of the pixel two edges older.
    initial begin
        exp_t        e;
        logic [31:0] exp_addr;
        logic [27:0] exp_out;
        logic [7:0]  pix;
        forever begin
            @(negedge gpu_clk);
            exp_addr = (!rst || q.size() == 0) ? BASE : q[$].addr;
            exp_out  = RST_OUT;
            if (rst && q.size() == 3) begin
                e       = q.pop_front();
                pix     = (e.iw && e.bl && de_s) ? e.addr[7:0] : 8'h00;
                exp_out = {e.hs, e.vs, e.bl, e.fs, pix, pix, pix};
            end
            checks++;
            if (bus.gpu_address !== exp_addr) begin
                failures++;
                $display("FAIL sb_addr t=%0t: got %h, expected %h", $time, bus.gpu_address,
                         exp_addr);
            end
            checks++;
            if (outv !== exp_out) begin
                failures++;
                $display("FAIL sb_out t=%0t: got %h, expected %h", $time, outv, exp_out);
            end
        end
    end

    task automatic wait_pixel(input int h, input int v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < FRAME + H_TOTAL && !ok; i++) begin
            @(posedge gpu_clk);
            #1;
            if (rst && last_h == h && last_v == v) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge gpu_clk);
        checks++;
        if (bus.gpu_address !== BASE) begin
            failures++;
            $display("FAIL reset_addr: got %h, expected %h", bus.gpu_address, BASE);
        end
        checks++;
        if (outv !== RST_OUT) begin
            failures++;
            $display("FAIL reset_out: got %h, expected %h", outv, RST_OUT);
        end
        #2 rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge gpu_clk);
            #1;
            checks++;
            if (bus.frame_start !== (k == 3)) begin
                failures++;
                $display("FAIL reset_fs_edge%0d: got %b, expected %b", k, bus.frame_start,
                         (k == 3));
            end
        end
    endtask

    task automatic test_timing();
        bit ok = 1'b0;
        int hs_low = 0, vs_low = 0, bl_hi = 0, fs_n = 0;
        int hs_run = 0, vs_run = 0, last_fs = 0, last_fall = -1;
        logic prev_hs;
        for (int i = 0; i < FRAME + 10 && !ok; i++) begin
            @(posedge gpu_clk);
            #1;
            if (bus.frame_start === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL timing_fs_wait: got timeout, expected frame_start pulse");
        end
        prev_hs = bus.hsync;
        for (int i = 1; i <= 2 * FRAME; i++) begin
            @(posedge gpu_clk);
            #1;
            if (prev_hs && !bus.hsync) begin
                if (last_fall >= 0) begin
                    checks++;
                    if (i - last_fall != H_TOTAL) begin
                        failures++;
                        $display("FAIL hsync_period: got %0d, expected %0d", i - last_fall,
                                 H_TOTAL);
                    end
                end
                last_fall = i;
            end
            prev_hs = bus.hsync;
            if (!bus.hsync) begin
                hs_low++;
                hs_run++;
            end else if (hs_run != 0) begin
                checks++;
                if (hs_run != H_SYNC) begin
                    failures++;
                    $display("FAIL hsync_width: got %0d, expected %0d", hs_run, H_SYNC);
                end
                hs_run = 0;
            end
            if (!bus.vsync) begin
                vs_low++;
                vs_run++;
            end else if (vs_run != 0) begin
                checks++;
                if (vs_run != V_SYNC * H_TOTAL) begin
                    failures++;
                    $display("FAIL vsync_width: got %0d, expected %0d", vs_run, V_SYNC * H_TOTAL);
                end
                vs_run = 0;
            end
            if (bus.blank_n) bl_hi++;
            if (bus.frame_start) begin
                fs_n++;
                checks++;
                if (i - last_fs != FRAME) begin
                    failures++;
                    $display("FAIL fs_period: got %0d, expected %0d", i - last_fs, FRAME);
                end
                last_fs = i;
            end
        end
        checks++;
        if (hs_low != 2 * V_TOTAL * H_SYNC) begin
            failures++;
            $display("FAIL hsync_total: got %0d, expected %0d", hs_low, 2 * V_TOTAL * H_SYNC);
        end
        checks++;
        if (vs_low != 2 * V_SYNC * H_TOTAL) begin
            failures++;
            $display("FAIL vsync_total: got %0d, expected %0d", vs_low, 2 * V_SYNC * H_TOTAL);
        end
        checks++;
        if (bl_hi != 2 * V_ACTIVE * H_ACTIVE) begin
            failures++;
            $display("FAIL blank_total: got %0d, expected %0d", bl_hi, 2 * V_ACTIVE * H_ACTIVE);
        end
        checks++;
        if (fs_n != 2) begin
            failures++;
            $display("FAIL fs_count: got %0d, expected 2", fs_n);
        end
    endtask

    task automatic test_address();
        bit ok;
        wait_pixel(AX, AY, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL addr_wait: got timeout, expected pixel (%0d,%0d)", AX, AY);
        end
        checks++;
        if (bus.gpu_address !== 32'h10BA) begin
            failures++;
            $display("FAIL addr_value: got %h, expected 000010ba", bus.gpu_address);
        end
        repeat (2) @(posedge gpu_clk);
        #1;
        checks++;
        if ({bus.r, bus.g, bus.b} !== 24'hBABABA) begin
            failures++;
            $display("FAIL addr_pixel: got %h, expected bababa", {bus.r, bus.g, bus.b});
        end
    endtask

    task automatic test_window_edge();
        bit ok;
        wait_pixel(X0 - 1, Y0, ok);
        checks++;
        if (!ok || bus.gpu_address !== BASE) begin
            failures++;
            $display("FAIL edge_left_addr: got %h ok=%b, expected %h", bus.gpu_address, ok, BASE);
        end
        repeat (2) @(posedge gpu_clk);
        #1;
        checks++;
        if ({bus.blank_n, bus.r, bus.g, bus.b} !== 25'h1000000) begin
            failures++;
            $display("FAIL edge_left_out: got %h, expected 1000000",
                     {bus.blank_n, bus.r, bus.g, bus.b});
        end
        wait_pixel(LAST_X, Y0, ok);
        checks++;
        if (!ok || bus.gpu_address !== LAST_ADDR) begin
            failures++;
            $display("FAIL edge_last_addr: got %h ok=%b, expected %h", bus.gpu_address, ok,
                     LAST_ADDR);
        end
        @(posedge gpu_clk);
        #1;
        checks++;
        if (bus.gpu_address !== BASE) begin
            failures++;
            $display("FAIL edge_after_addr: got %h, expected %h", bus.gpu_address, BASE);
        end
        @(posedge gpu_clk);
        #1;
        checks++;
        if ({bus.blank_n, bus.r, bus.g, bus.b} !== {1'b1, {3{LAST_ADDR[7:0]}}}) begin
            failures++;
            $display("FAIL edge_last_out: got %h, expected %h", {bus.blank_n, bus.r, bus.g, bus.b},
                     {1'b1, {3{LAST_ADDR[7:0]}}});
        end
        @(posedge gpu_clk);
        #1;
        checks++;
        if ({bus.blank_n, bus.r, bus.g, bus.b} !== {AFTER_BL, 24'h0}) begin
            failures++;
            $display("FAIL edge_after_out: got %h, expected %h",
                     {bus.blank_n, bus.r, bus.g, bus.b}, {AFTER_BL, 24'h0});
        end
        wait_pixel(X0 + 1, BLACK_V, ok);
        checks++;
        if (!ok || bus.gpu_address !== BASE) begin
            failures++;
            $display("FAIL edge_below_addr: got %h ok=%b, expected %h", bus.gpu_address, ok, BASE);
        end
        repeat (2) @(posedge gpu_clk);
        #1;
        checks++;
        if ({bus.blank_n, bus.r, bus.g, bus.b} !== 25'h1000000) begin
            failures++;
            $display("FAIL edge_below_out: got %h, expected 1000000",
                     {bus.blank_n, bus.r, bus.g, bus.b});
        end
    endtask

    task automatic test_display_en();
        bit ok;
        int seen = 0;
        wait_pixel(0, Y0 + 1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL de_wait: got timeout, expected pixel (0,%0d)", Y0 + 1);
        end
        display_en = 1'b0;
        for (int i = 0; i < H_TOTAL; i++) begin
            @(posedge gpu_clk);
            #1;
            if (bus.blank_n) seen++;
            checks++;
            if ({bus.r, bus.g, bus.b} !== 24'h0) begin
                failures++;
                $display("FAIL de_black: got %h, expected 000000", {bus.r, bus.g, bus.b});
            end
        end
        display_en = 1'b1;
        checks++;
        if (seen != H_ACTIVE) begin
            failures++;
            $display("FAIL de_blank_count: got %0d, expected %0d", seen, H_ACTIVE);
        end
    endtask

    task automatic test_reset_mid_line();
        bit ok;
        int cnt = 0;
        wait_pixel(30, 10, ok);
        rst = 1'b0;
        #1;
        checks++;
        if (!ok || bus.gpu_address !== BASE || outv !== RST_OUT) begin
            failures++;
            $display("FAIL midreset_async: got addr %h out %h ok=%b, expected %h %h",
                     bus.gpu_address, outv, ok, BASE, RST_OUT);
        end
        repeat (5) @(posedge gpu_clk);
        @(negedge gpu_clk);
        #2 rst = 1'b1;
        ok = 1'b0;
        while (!ok && cnt < 10) begin
            @(posedge gpu_clk);
            cnt++;
            #1;
            if (bus.frame_start === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok || cnt != 3) begin
            failures++;
            $display("FAIL midreset_fs: got edge %0d ok=%b, expected edge 3", cnt, ok);
        end
        cnt = 0;
        ok = 1'b0;
        while (!ok && cnt < FRAME + 10) begin
            @(posedge gpu_clk);
            cnt++;
            #1;
            if (bus.vsync === 1'b0) ok = 1'b1;
        end
        checks++;
        if (!ok || cnt != (V_ACTIVE + V_FP) * H_TOTAL) begin
            failures++;
            $display("FAIL midreset_vsync: got %0d ok=%b, expected %0d", cnt, ok,
                     (V_ACTIVE + V_FP) * H_TOTAL);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        test_reset();
        test_timing();
        test_address();
        test_window_edge();
        test_display_en();
        test_reset_mid_line();
        repeat (H_TOTAL) @(posedge gpu_clk);
        @(negedge gpu_clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
